// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix one row per slot,
// assembles a 16-bit frame every four slots, debounces frame results and
// reports one code/valid event per accepted key press.
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 2000,  // clocks per row slot, 4..65535
  parameter int unsigned DEBOUNCE = 4      // identical frames to accept, 1..15
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic [3:0] col,        // active-low columns, asynchronous to clk
  output logic [3:0] row,        // active-low one-cold row drive
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_e;

  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] code;   // meaningful only for RES_SINGLE, zero otherwise
  } frame_res_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_e;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE);

  // Synchroniser, prescaler and scan registers
  logic [3:0]  col_s1_q, col_s2_q;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [3:0]  row_q, row_d;
  logic [15:0] acc_q, acc_d;

  // Debounce and event registers
  frame_res_t  prev_res_q, prev_res_d;
  logic [3:0]  stab_q, stab_d;
  state_e      state_q, state_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  // Combinational helpers
  logic        tick;
  logic        frame_end;
  logic [15:0] frame_bits;
  frame_res_t  cur_res;

  assign tick      = (div_cnt_q == DIV_LAST);
  assign frame_end = tick && (row_idx_q == 2'd3);

  // Two-flop synchroniser for the asynchronous column inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, giving a true two-stage chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
    end
  end

  // Prescaler, row sequencing and frame accumulation.
  // NOTE: every output of a combinational block receives a default first, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
    row_idx_d = row_idx_q;
    row_d     = row_q;
    acc_d     = acc_q;
    // Current row's active-high key bits merged into the partial frame.
    frame_bits = acc_q | ({12'd0, ~col_s2_q} << {row_idx_q, 2'b00});
    if (tick) begin
      row_idx_d = row_idx_q + 2'd1;
      row_d     = ~(4'b0001 << row_idx_d);
      acc_d     = frame_end ? 16'd0 : frame_bits;
    end
  end

  // Classify the completed frame as NONE, SINGLE(code) or MULTI.
  always_comb begin
    cur_res.kind = RES_NONE;
    cur_res.code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_bits[i]) begin
        if (cur_res.kind == RES_NONE) begin
          cur_res.kind = RES_SINGLE;
          cur_res.code = 4'(i);
        end else begin
          cur_res.kind = RES_MULTI;
          cur_res.code = 4'd0;
        end
      end
    end
  end

  // Stability counter: counts consecutive identical non-MULTI frame results.
  always_comb begin
    prev_res_d = prev_res_q;
    stab_d     = stab_q;
    if (frame_end) begin
      prev_res_d = cur_res;
      if (cur_res.kind == RES_MULTI) begin
        stab_d = 4'd0;
      end else if (cur_res == prev_res_q) begin
        stab_d = (stab_q >= DEB_MAX) ? DEB_MAX : stab_q + 4'd1;
      end else begin
        stab_d = 4'd1;
      end
    end
  end

  // Press/release state machine, evaluated only when a frame closes.
  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (cur_res.kind == RES_SINGLE && stab_d == DEB_MAX) begin
            state_d     = ST_PRESSED;
            key_code_d  = cur_res.code;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end
        end
        ST_PRESSED: begin
          // A different single key or a chord while held is ignored.
          if (cur_res.kind == RES_NONE && stab_d == DEB_MAX) begin
            state_d    = ST_IDLE;
            key_held_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register for scan, debounce and event logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= 16'd0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      acc_q       <= 16'd0;
      prev_res_q  <= '{kind: RES_NONE, code: 4'd0};
      stab_q      <= 4'd0;
      state_q     <= ST_IDLE;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      prev_res_q  <= prev_res_d;
      stab_q      <= stab_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
